// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA controller.
package dmac_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned WAIT_W     = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        DMA_NONE = 2'b00,
        DMA_D2S  = 2'b01,
        DMA_S2D  = 2'b10
    } dma_cmd_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_D2S_RD = 3'd1,
        ST_D2S_WR = 3'd2,
        ST_S2D_RD = 3'd3,
        ST_S2D_WR = 3'd4,
        ST_DONE   = 3'd5
    } dmac_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmac_xfer_regs.sv
// Source/destination/count registers for one DMA transfer.
module dmac_xfer_regs
    import dmac_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [CNT_W-1:0]  count,
    output logic              last
);

    // Load on command capture, advance one word per completed copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            src   <= '0;
            dst   <= '0;
            count <= '0;
        end else if (load) begin
            src   <= word_align(src_in);
            dst   <= word_align(dst_in);
            count <= cnt_in;
        end else if (step) begin
            src <= src + ADDR_W'(WORD_BYTES);
            dst <= dst + ADDR_W'(WORD_BYTES);
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/dmac.sv
// DMA controller: word-by-word copies between DDR and the data SRAM.
module dmac
    import dmac_pkg::*;
#(
    parameter int unsigned DDR_ACK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        dmaCmd,
    input  logic [ADDR_W-1:0] dmaSrcAddress,
    input  logic [ADDR_W-1:0] dmaDstAddress,
    input  logic [CNT_W-1:0]  dmaWidth,
    output logic              stall,
    output logic              sramOwn,
    output logic [ADDR_W-1:0] sramAddress,
    output logic              sramWriteEnable,
    output logic [DATA_W-1:0] sramWriteData,
    input  logic [DATA_W-1:0] sramReadData,
    output logic              ddrReq,
    output logic              ddrWe,
    output logic [ADDR_W-1:0] ddrAddress,
    output logic [DATA_W-1:0] ddrWriteData,
    input  logic [DATA_W-1:0] ddrReadData,
    input  logic              ddrAck,
    output logic              dmaError
);

    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_D2S_RD = STATE_W'(ST_D2S_RD);
    localparam logic [STATE_W-1:0] S_D2S_WR = STATE_W'(ST_D2S_WR);
    localparam logic [STATE_W-1:0] S_S2D_RD = STATE_W'(ST_S2D_RD);
    localparam logic [STATE_W-1:0] S_S2D_WR = STATE_W'(ST_S2D_WR);
    localparam logic [STATE_W-1:0] S_DONE   = STATE_W'(ST_DONE);

    logic [STATE_W-1:0] state, state_nxt_c;
    logic [ADDR_W-1:0]  src, dst;
    logic [CNT_W-1:0]   count;
    logic               last;
    logic [DATA_W-1:0]  word;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               load_c, step_c, latch_ddr_c, latch_sram_c;
    logic               wait_clr_c, timeout_hit_c, timeout_now_c, accept_c;

    dmac_xfer_regs u_regs (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .step   (step_c),
        .src_in (dmaSrcAddress),
        .dst_in (dmaDstAddress),
        .cnt_in (dmaWidth),
        .src    (src),
        .dst    (dst),
        .count  (count),
        .last   (last)
    );

    assign accept_c      = (dmaCmd == 2'(DMA_D2S)) || (dmaCmd == 2'(DMA_S2D));
    assign timeout_now_c = (WAIT_W'(DDR_ACK_TIMEOUT) != '0) &&
                           (wait_cnt == WAIT_W'(DDR_ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt_c;
        end
    end

    // Next-state and port decode; the SRAM and DDR ports are driven only in their owning states.
    always_comb begin
        state_nxt_c     = state;
        stall           = 1'b0;
        sramOwn         = 1'b0;
        sramAddress     = '0;
        sramWriteEnable = 1'b0;
        sramWriteData   = '0;
        ddrReq          = 1'b0;
        ddrWe           = 1'b0;
        ddrAddress      = '0;
        ddrWriteData    = '0;
        load_c          = 1'b0;
        step_c          = 1'b0;
        latch_ddr_c     = 1'b0;
        latch_sram_c    = 1'b0;
        wait_clr_c      = 1'b0;
        timeout_hit_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    stall      = 1'b1;
                    load_c     = 1'b1;
                    wait_clr_c = 1'b1;
                    if (dmaWidth == '0) begin
                        state_nxt_c = S_DONE;
                    end else if (dmaCmd == 2'(DMA_D2S)) begin
                        state_nxt_c = S_D2S_RD;
                    end else begin
                        state_nxt_c = S_S2D_RD;
                    end
                end
            end
            S_D2S_RD: begin
                stall      = 1'b1;
                sramOwn    = 1'b1;
                ddrReq     = 1'b1;
                ddrAddress = src;
                if (ddrAck) begin
                    latch_ddr_c = 1'b1;
                    state_nxt_c = S_D2S_WR;
                end else if (timeout_now_c) begin
                    timeout_hit_c = 1'b1;
                    state_nxt_c   = S_DONE;
                end
            end
            S_D2S_WR: begin
                stall           = 1'b1;
                sramOwn         = 1'b1;
                sramWriteEnable = 1'b1;
                sramAddress     = dst;
                sramWriteData   = word;
                step_c          = 1'b1;
                wait_clr_c      = 1'b1;
                state_nxt_c     = last ? S_DONE : S_D2S_RD;
            end
            S_S2D_RD: begin
                stall        = 1'b1;
                sramOwn      = 1'b1;
                sramAddress  = src;
                latch_sram_c = 1'b1;
                wait_clr_c   = 1'b1;
                state_nxt_c  = S_S2D_WR;
            end
            S_S2D_WR: begin
                stall        = 1'b1;
                sramOwn      = 1'b1;
                ddrReq       = 1'b1;
                ddrWe        = 1'b1;
                ddrAddress   = dst;
                ddrWriteData = word;
                if (ddrAck) begin
                    step_c      = 1'b1;
                    state_nxt_c = last ? S_DONE : S_S2D_RD;
                end else if (timeout_now_c) begin
                    timeout_hit_c = 1'b1;
                    state_nxt_c   = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt_c = S_IDLE;
            end
            default: begin
                state_nxt_c = S_IDLE;
            end
        endcase
    end

    // Word in flight between the read side and the write side.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (latch_ddr_c) begin
            word <= ddrReadData;
        end else if (latch_sram_c) begin
            word <= sramReadData;
        end
    end

    // Cycles spent waiting on the current DDR request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (wait_clr_c) begin
            wait_cnt <= '0;
        end else if (ddrReq) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky timeout flag, cleared when a new command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmaError <= 1'b0;
        end else if (state == S_IDLE && accept_c) begin
            dmaError <= 1'b0;
        end else if (timeout_hit_c) begin
            dmaError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmac.sv
// Scoreboard bench for dmac: bench-side SRAM and DDR models, expected bus events queued per command.
module tb_dmac;

    typedef struct {
        int          kind;   // 0 DDR read, 1 DDR write, 2 SRAM write
        logic [31:0] addr;
        logic [31:0] data;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dmaCmd;
    logic [31:0] dmaSrcAddress, dmaDstAddress;
    logic [9:0]  dmaWidth;
    logic        stall, sramOwn, sramWriteEnable, ddrReq, ddrWe, ddrAck, dmaError;
    logic [31:0] sramAddress, sramWriteData, sramReadData;
    logic [31:0] ddrAddress, ddrWriteData, ddrReadData;

    logic [31:0] smem    [256];
    logic [31:0] dmem    [256];
    logic [31:0] exp_mem [256];
    evt_t        exp_q [$];
    evt_t        e_mon;

    int total = 0;
    int bad   = 0;
    int cur_lat = 1;
    int wait_cyc = 0;
    int req_rises = 0;
    int req_cycles = 0;
    logic        req_prev = 1'b0;
    logic [31:0] held_addr, held_data;
    logic        held_we;

    dmac #(.DDR_ACK_TIMEOUT(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmaCmd          (dmaCmd),
        .dmaSrcAddress   (dmaSrcAddress),
        .dmaDstAddress   (dmaDstAddress),
        .dmaWidth        (dmaWidth),
        .stall           (stall),
        .sramOwn         (sramOwn),
        .sramAddress     (sramAddress),
        .sramWriteEnable (sramWriteEnable),
        .sramWriteData   (sramWriteData),
        .sramReadData    (sramReadData),
        .ddrReq          (ddrReq),
        .ddrWe           (ddrWe),
        .ddrAddress      (ddrAddress),
        .ddrWriteData    (ddrWriteData),
        .ddrReadData     (ddrReadData),
        .ddrAck          (ddrAck),
        .dmaError        (dmaError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM: asynchronous read, write on the clock edge.
    assign sramReadData = smem[sramAddress[9:2]];
    always @(posedge clk) begin
        if (sramWriteEnable) smem[sramAddress[9:2]] = sramWriteData;
    end

    // DDR responder: ack cur_lat cycles after ddrReq rises (cur_lat 0 = never).
    always @(negedge clk) begin
        if (ddrReq && !reset) begin
            wait_cyc++;
            if (cur_lat != 0 && wait_cyc == cur_lat) begin
                ddrAck      = 1'b1;
                ddrReadData = dmem[ddrAddress[9:2]];
                if (ddrWe) dmem[ddrAddress[9:2]] = ddrWriteData;
            end else begin
                ddrAck = 1'b0;
            end
        end else begin
            wait_cyc = 0;
            ddrAck   = 1'b0;
        end
    end

    // Monitor: pop the scoreboard on each new DDR request and each SRAM write.
    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
        end else begin
            if (ddrReq) begin
                req_cycles++;
                if (!req_prev) begin
                    req_rises++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ddr_req: addr %0h we %0b, expected none", ddrAddress, ddrWe);
                    end else begin
                        e_mon = exp_q.pop_front();
                        chk("ddr_kind", ddrWe ? 32'd1 : 32'd0, 32'(e_mon.kind));
                        chk("ddr_addr", ddrAddress, e_mon.addr);
                        if (e_mon.kind == 1) chk("ddr_wdata", ddrWriteData, e_mon.data);
                    end
                end else begin
                    chk("ddr_addr_stable", ddrAddress, held_addr);
                    chk("ddr_we_stable", 32'(ddrWe), 32'(held_we));
                    chk("ddr_wdata_stable", ddrWriteData, held_data);
                end
                held_addr = ddrAddress;
                held_we   = ddrWe;
                held_data = ddrWriteData;
            end
            if (sramWriteEnable) begin
                chk("sram_own", 32'(sramOwn), 32'd1);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_sram_wr: addr %0h data %0h, expected none", sramAddress, sramWriteData);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("sram_kind", 32'd2, 32'(e_mon.kind));
                    chk("sram_addr", sramAddress, e_mon.addr);
                    chk("sram_wdata", sramWriteData, e_mon.data);
                end
            end
            req_prev = ddrReq;
        end
    end

    // Issue one command, wait for stall to fall, then check cycle count, events and destination memory.
    task automatic run_xfer(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                            input int width, input int lat, input bit hold, input string tag);
        logic [31:0] sa, da, a_s, a_d, w;
        int n, diffs, exp_stall;
        sa = {src[31:2], 2'b00};
        da = {dst[31:2], 2'b00};
        for (int k = 0; k < 256; k++) exp_mem[k] = (cmd == 2'b01) ? smem[k] : dmem[k];
        for (int i = 0; i < width; i++) begin
            a_s = sa + 32'(4 * i);
            a_d = da + 32'(4 * i);
            if (cmd == 2'b01) begin
                w = dmem[a_s[9:2]];
                exp_q.push_back('{0, a_s, 32'd0});
                exp_q.push_back('{2, a_d, w});
            end else begin
                w = smem[a_s[9:2]];
                exp_q.push_back('{1, a_d, w});
            end
            exp_mem[a_d[9:2]] = w;
        end
        exp_stall = 1 + width * (lat + 1);
        cur_lat = lat;
        @(posedge clk); #1;
        dmaCmd = cmd; dmaSrcAddress = src; dmaDstAddress = dst; dmaWidth = 10'(width);
        n = 0;
        @(negedge clk);
        while (stall && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (!hold) dmaCmd = 2'b00;
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        chk({tag, "_error"}, 32'(dmaError), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        diffs = 0;
        for (int k = 0; k < 256; k++) begin
            if (((cmd == 2'b01) ? smem[k] : dmem[k]) !== exp_mem[k]) diffs++;
        end
        chk({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
        if (hold) begin
            @(posedge clk); #1;
            dmaCmd = 2'b00;
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0;
        logic [1:0] rc;
        reset = 1'b1; dmaCmd = 2'b00; dmaSrcAddress = '0; dmaDstAddress = '0; dmaWidth = '0;
        ddrAck = 1'b0; ddrReadData = '0;
        for (int k = 0; k < 256; k++) begin
            smem[k] = $urandom();
            dmem[k] = $urandom();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sram_own", 32'(sramOwn), 32'd0);
        chk("rst_sram_we", 32'(sramWriteEnable), 32'd0);
        chk("rst_ddr_req", 32'(ddrReq), 32'd0);
        chk("rst_ddr_we", 32'(ddrWe), 32'd0);
        chk("rst_error", 32'(dmaError), 32'd0);
        chk("rst_sram_addr", sramAddress, 32'd0);
        chk("rst_ddr_addr", ddrAddress, 32'd0);
        chk("rst_ddr_wdata", ddrWriteData, 32'd0);
        chk("rst_sram_wdata", sramWriteData, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed d2s: DDR words 6..9 -> SRAM words 3..6, 1-cycle ack.
        dmem[6] = 32'd123; dmem[7] = 32'd456; dmem[8] = 32'd789; dmem[9] = 32'd5555;
        run_xfer(2'b01, 32'd24, 32'd12, 4, 1, 1'b0, "d2s_plan");
        chk("d2s_plan_sram3", smem[3], 32'd123);
        chk("d2s_plan_sram6", smem[6], 32'd5555);

        // Directed s2d: SRAM 0..2 -> DDR 0x100.., 3-cycle ack.
        smem[0] = 32'd7; smem[1] = 32'd8; smem[2] = 32'd9;
        run_xfer(2'b10, 32'd0, 32'h100, 3, 3, 1'b0, "s2d_plan");
        chk("s2d_plan_ddr", dmem[66], 32'd9);

        // Zero width: one stall cycle, no bus activity.
        r0 = req_rises;
        run_xfer(2'b01, 32'd40, 32'd80, 0, 1, 1'b0, "width0");
        chk("width0_no_req", 32'(req_rises), 32'(r0));

        // Command held through DONE must not restart a transfer.
        run_xfer(2'b01, 32'd200, 32'd300, 2, 2, 1'b1, "hold");
        r0 = req_rises;
        repeat (4) begin
            @(negedge clk);
            chk("hold_no_restall", 32'(stall), 32'd0);
        end
        chk("hold_no_req", 32'(req_rises), 32'(r0));

        // Command 11 is ignored.
        @(posedge clk); #1;
        dmaCmd = 2'b11; dmaWidth = 10'd3;
        repeat (4) begin
            @(negedge clk);
            chk("cmd11_stall", 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        dmaCmd = 2'b00;
        chk("cmd11_no_req", 32'(req_rises), 32'(r0));

        // Address wrap past 2^32, misaligned inputs, ack on the last cycle before the timeout.
        run_xfer(2'b01, 32'hFFFF_FFF9, 32'h0000_03FE, 4, 5, 1'b0, "wrap_d2s");
        run_xfer(2'b10, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 4, 5, 1'b0, "wrap_s2d");

        // Timeout: DDR never acks; request held exactly 5 cycles, error flagged and sticky.
        exp_q.push_back('{0, 32'h40, 32'd0});
        cur_lat = 0;
        req_cycles = 0;
        @(posedge clk); #1;
        dmaCmd = 2'b01; dmaSrcAddress = 32'h40; dmaDstAddress = 32'h80; dmaWidth = 10'd3;
        n = 0;
        @(negedge clk);
        while (stall && n < 5000) begin
            n++;
            @(negedge clk);
        end
        dmaCmd = 2'b00;
        chk("timeout_stall_cycles", 32'(n), 32'd6);
        chk("timeout_req_cycles", 32'(req_cycles), 32'd5);
        chk("timeout_req_dropped", 32'(ddrReq), 32'd0);
        chk("timeout_error", 32'(dmaError), 32'd1);
        chk("timeout_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_error_sticky", 32'(dmaError), 32'd1);
        exp_q.delete();
        run_xfer(2'b01, 32'h44, 32'h84, 1, 1, 1'b0, "after_timeout");

        // Reset during the second DDR read of a 4-word d2s: only the first word lands.
        dmem[6] = 32'd123; dmem[7] = 32'd456;
        for (int k = 3; k < 7; k++) smem[k] = 32'hDEAD_0000 + 32'(k);
        exp_q.push_back('{0, 32'd24, 32'd0});
        exp_q.push_back('{2, 32'd12, 32'd123});
        exp_q.push_back('{0, 32'd28, 32'd0});
        cur_lat = 3;
        r0 = req_rises;
        @(posedge clk); #1;
        dmaCmd = 2'b01; dmaSrcAddress = 32'd24; dmaDstAddress = 32'd12; dmaWidth = 10'd4;
        n = 0;
        @(negedge clk);
        while (req_rises < r0 + 2 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("rstmid_reached_rd2", 32'(req_rises - r0), 32'd2);
        @(posedge clk); #1;
        reset = 1'b1; dmaCmd = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_ddr_req", 32'(ddrReq), 32'd0);
        chk("rstmid_sram_own", 32'(sramOwn), 32'd0);
        chk("rstmid_pending", 32'(exp_q.size()), 32'd0);
        chk("rstmid_sram3", smem[3], 32'd123);
        chk("rstmid_sram4", smem[4], 32'hDEAD_0004);
        chk("rstmid_sram6", smem[6], 32'hDEAD_0006);
        exp_q.delete();

        // Randomized transfers.
        for (int t = 0; t < 25; t++) begin
            rc = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            run_xfer(rc, $urandom(), $urandom(), $urandom_range(0, 10), $urandom_range(1, 5),
                     1'b0, "rand");
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
